// File: rtl/square_draw_arbiter.sv
// square_draw_arbiter
// Round-robin scheduler that shares one VGA plot port among NUM_REQ
// square-draw requesters. Draws one SIZE x SIZE square at a time in raster
// order (dx fastest), one pixel per clock, then pulses done for the winner.
//
// Handshake: req[i] is a level request. A requester is served when the
// arbiter is IDLE and picks it; grant[i] stays high for every DRAW cycle of
// its square, and done[i] pulses for one cycle afterwards. The requester
// must drop req[i] in that done cycle. If req[i] is still high in the
// following IDLE cycle, the arbiter treats it as a new request. Once granted,
// the square always completes, even if req drops mid-square; only reset can
// abandon it.
module square_draw_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int SIZE    = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   x_in,
    input  logic [7*NUM_REQ-1:0]   y_in,
    input  logic [3*NUM_REQ-1:0]   colour_in,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     done,
    output logic [7:0]             vga_x,
    output logic [6:0]             vga_y,
    output logic [2:0]             vga_colour,
    output logic                   plot,
    output logic                   busy,
    output logic [1:0]             dbg_state
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int HW    = $clog2(SIZE);
    localparam int CW    = 2 * HW;
    localparam logic [CW-1:0] LAST = CW'(SIZE * SIZE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, next_state;
    logic [CW-1:0]     cnt;
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  win;
    logic [7:0]        x_lat;
    logic [6:0]        y_lat;
    logic [2:0]        c_lat;

    logic              any_req;
    logic              found_hi, found_lo;
    logic [PTR_W-1:0]  pick_hi, pick_lo, pick;
    logic [7:0]        sel_x;
    logic [6:0]        sel_y;
    logic [2:0]        sel_c;
    logic [PTR_W-1:0]  ptr_after_win;
    logic [HW-1:0]     dx, dy;

    assign dx = cnt[HW-1:0];
    assign dy = cnt[CW-1:HW];

    // Round-robin pick: first requester at or above rr_ptr, else the lowest
    // set requester (wrap-around), then the winner's coordinates/colour.
    always_comb begin
        any_req  = |req;
        found_hi = 1'b0;
        found_lo = 1'b0;
        pick_hi  = '0;
        pick_lo  = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found_hi && req[j] && (PTR_W'(j) >= rr_ptr)) begin
                found_hi = 1'b1;
                pick_hi  = PTR_W'(j);
            end
            if (!found_lo && req[j]) begin
                found_lo = 1'b1;
                pick_lo  = PTR_W'(j);
            end
        end
        pick  = found_hi ? pick_hi : pick_lo;
        sel_x = '0;
        sel_y = '0;
        sel_c = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (pick == PTR_W'(j)) begin
                sel_x = x_in[8*j +: 8];
                sel_y = y_in[7*j +: 7];
                sel_c = colour_in[3*j +: 3];
            end
        end
        ptr_after_win = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + PTR_W'(1);
    end

    // Next-state logic for the IDLE -> DRAW -> DONE -> IDLE sequence.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_req) next_state = DRAW;
            DRAW:    if (cnt == LAST) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register plus winner latch, pixel counter and round-robin pointer.
    // The counter stops on the last pixel so the VGA outputs keep showing it
    // until the next square starts.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= IDLE;
            cnt    <= '0;
            rr_ptr <= '0;
            win    <= '0;
            x_lat  <= '0;
            y_lat  <= '0;
            c_lat  <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        win   <= pick;
                        x_lat <= sel_x;
                        y_lat <= sel_y;
                        c_lat <= sel_c;
                        cnt   <= '0;
                    end
                end
                DRAW: begin
                    if (cnt != LAST) cnt <= cnt + CW'(1);
                end
                DONE: begin
                    rr_ptr <= ptr_after_win;
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from registered state only; pixel address wraps per axis.
    always_comb begin
        plot       = (state == DRAW);
        busy       = (state != IDLE);
        dbg_state  = state;
        vga_x      = x_lat + 8'(dx);
        vga_y      = y_lat + 7'(dy);
        vga_colour = c_lat;
        grant      = '0;
        done       = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            grant[j] = (state == DRAW) && (win == PTR_W'(j));
            done[j]  = (state == DONE) && (win == PTR_W'(j));
        end
    end

endmodule

// File: tb/tb_square_draw_arbiter.sv
// Directed testbench for square_draw_arbiter (NUM_REQ=4, SIZE=4).
module tb_square_draw_arbiter;

    localparam int NUM_REQ = 4;
    localparam int SIZE    = 4;

    logic                 clk;
    logic                 resetn;
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] x_in;
    logic [7*NUM_REQ-1:0] y_in;
    logic [3*NUM_REQ-1:0] colour_in;
    logic [NUM_REQ-1:0]   grant;
    logic [NUM_REQ-1:0]   done;
    logic [7:0]           vga_x;
    logic [6:0]           vga_y;
    logic [2:0]           vga_colour;
    logic                 plot;
    logic                 busy;
    logic [1:0]           dbg_state;

    int n_asserts = 0;
    int n_fail    = 0;

    square_draw_arbiter #(.NUM_REQ(NUM_REQ), .SIZE(SIZE)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req        (req),
        .x_in       (x_in),
        .y_in       (y_in),
        .colour_in  (colour_in),
        .grant      (grant),
        .done       (done),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .plot       (plot),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled and inputs driven 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_asserts++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        req    = '0;
        step();
        step();
        resetn = 1'b1;
    endtask

    task automatic set_data(input int idx, input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
        x_in[8*idx +: 8]      = x;
        y_in[7*idx +: 7]      = y;
        colour_in[3*idx +: 3] = c;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_plot"},  32'(plot),  0);
        check({tag, "_busy"},  32'(busy),  0);
        check({tag, "_grant"}, 32'(grant), 0);
        check({tag, "_done"},  32'(done),  0);
    endtask

    // Called in the first DRAW cycle. Checks every pixel, the done cycle and
    // the IDLE cycle after it. req_at_done is driven during the done cycle.
    // With scramble set, inputs are disturbed and req dropped after pixel 5.
    task automatic draw_square(input int idx, input logic [7:0] x0, input logic [6:0] y0,
                               input logic [2:0] c0, input logic [NUM_REQ-1:0] req_at_done,
                               input bit scramble, input string tag);
        logic [7:0] ex;
        logic [6:0] ey;
        logic [NUM_REQ-1:0] onehot;
        onehot = '0;
        onehot[idx] = 1'b1;
        for (int k = 0; k < SIZE*SIZE; k++) begin
            ex = x0 + 8'(k % SIZE);
            ey = y0 + 7'(k / SIZE);
            check({tag, "_plot"},   32'(plot),       1);
            check({tag, "_grant"},  32'(grant),      32'(onehot));
            check({tag, "_busy"},   32'(busy),       1);
            check({tag, "_done"},   32'(done),       0);
            check({tag, "_x"},      32'(vga_x),      32'(ex));
            check({tag, "_y"},      32'(vga_y),      32'(ey));
            check({tag, "_colour"}, 32'(vga_colour), 32'(c0));
            if (scramble && k == 5) begin
                x_in      = ~x_in;
                y_in      = ~y_in;
                colour_in = ~colour_in;
                req       = '0;
            end
            step();
        end
        check({tag, "_done_pulse"}, 32'(done),  32'(onehot));
        check({tag, "_done_plot"},  32'(plot),  0);
        check({tag, "_done_grant"}, 32'(grant), 0);
        check({tag, "_done_busy"},  32'(busy),  1);
        check({tag, "_hold_x"},     32'(vga_x), 32'(8'(x0 + 8'(SIZE-1))));
        check({tag, "_hold_y"},     32'(vga_y), 32'(7'(y0 + 7'(SIZE-1))));
        req = req_at_done;
        step();
        check_idle({tag, "_gap"});
        check({tag, "_gap_x"}, 32'(vga_x), 32'(8'(x0 + 8'(SIZE-1))));
    endtask

    // Directed stimulus sequence
    initial begin
        resetn    = 1'b0;
        req       = '0;
        x_in      = '0;
        y_in      = '0;
        colour_in = '0;

        // Reset state
        apply_reset();
        check_idle("rst");
        check("rst_x", 32'(vga_x), 0);
        check("rst_y", 32'(vga_y), 0);
        check("rst_c", 32'(vga_colour), 0);
        check("rst_state", 32'(dbg_state), 0);

        // 1: single requester, basic square
        set_data(0, 8'd10, 7'd20, 3'b100);
        req = 4'b0001;
        step();
        req = 4'b0000;
        draw_square(0, 8'd10, 7'd20, 3'b100, 4'b0000, 1'b0, "t1");
        step();
        check_idle("t1_stay_idle");

        // 2: two simultaneous requests after reset, requester 1 first
        apply_reset();
        set_data(1, 8'd40, 7'd5, 3'b011);
        set_data(2, 8'd80, 7'd9, 3'b110);
        req = 4'b0110;
        step();
        draw_square(1, 8'd40, 7'd5, 3'b011, 4'b0100, 1'b0, "t2a");
        step();
        draw_square(2, 8'd80, 7'd9, 3'b110, 4'b0000, 1'b0, "t2b");

        // 3: all requesting, rotation 0,1,2,3 then back to 0
        apply_reset();
        set_data(0, 8'd1,   7'd2,  3'd1);
        set_data(1, 8'd100, 7'd50, 3'd2);
        set_data(2, 8'd150, 7'd60, 3'd3);
        set_data(3, 8'd200, 7'd70, 3'd7);
        req = 4'b1111;
        step();
        draw_square(0, 8'd1,   7'd2,  3'd1, 4'b1110, 1'b0, "t3_r0");
        step();
        draw_square(1, 8'd100, 7'd50, 3'd2, 4'b1100, 1'b0, "t3_r1");
        step();
        draw_square(2, 8'd150, 7'd60, 3'd3, 4'b1000, 1'b0, "t3_r2");
        step();
        draw_square(3, 8'd200, 7'd70, 3'd7, 4'b0000, 1'b0, "t3_r3");
        req = 4'b1111;
        step();
        check("t3_wrap_grant", 32'(grant), 32'(4'b0001));
        req = 4'b0000;

        // 4: coordinate wrap on both axes
        apply_reset();
        set_data(0, 8'd254, 7'd126, 3'b010);
        req = 4'b0001;
        step();
        req = 4'b0000;
        draw_square(0, 8'd254, 7'd126, 3'b010, 4'b0000, 1'b0, "t4");

        // 5: reset during the 8th DRAW cycle abandons the square
        apply_reset();
        set_data(0, 8'd30, 7'd40, 3'b001);
        req = 4'b0001;
        step();
        for (int k = 0; k < 7; k++) begin
            check("t5_plot", 32'(plot), 1);
            check("t5_x", 32'(vga_x), 32'(30 + (k % 4)));
            step();
        end
        check("t5_x8", 32'(vga_x), 33);
        check("t5_y8", 32'(vga_y), 41);
        resetn = 1'b0;
        req    = 4'b0000;
        step();
        check_idle("t5_abort");
        check("t5_abort_x", 32'(vga_x), 0);
        resetn = 1'b1;
        step();
        check("t5_no_done", 32'(done), 0);
        set_data(1, 8'd50, 7'd60, 3'b101);
        req = 4'b0010;
        step();
        req = 4'b0000;
        draw_square(1, 8'd50, 7'd60, 3'b101, 4'b0000, 1'b0, "t5_new");

        // 6: inputs changed and req dropped mid-square
        apply_reset();
        set_data(2, 8'd100, 7'd10, 3'b010);
        req = 4'b0100;
        step();
        draw_square(2, 8'd100, 7'd10, 3'b010, 4'b0000, 1'b1, "t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
